// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: A - B - Bin, LSB first.
// start/busy/done handshake; results held until next completion.
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic [WIDTH-1:0] diff,
  output logic             Bout,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-2:0] r_res;
  logic             r_br;
  logic [CW-1:0]    r_cnt;

  logic             w_a;
  logic             w_b;
  logic             w_d;
  logic             w_nb;
  logic             w_last;
  logic [WIDTH-1:0] w_res;

  assign w_a    = r_a[0];
  assign w_b    = r_b[0];
  assign w_d    = w_a ^ w_b ^ r_br;
  assign w_nb   = (~w_a & w_b) | (~(w_a ^ w_b) & r_br);
  // New bit enters at the MSB; after WIDTH shifts bit 0 is the LSB.
  assign w_res  = {w_d, r_res};
  assign w_last = (r_cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_br    <= 1'b0;
      r_cnt   <= '0;
      diff    <= '0;
      Bout    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a     <= A;
            r_b     <= B;
            r_br    <= Bin;
            r_cnt   <= '0;
            busy    <= 1'b1;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_a   <= {1'b0, r_a[WIDTH-1:1]};
          r_b   <= {1'b0, r_b[WIDTH-1:1]};
          r_br  <= w_nb;
          r_res <= w_res[WIDTH-1:1];
          r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            diff    <= w_res;
            Bout    <= w_nb;
            done    <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor at WIDTH=4 and WIDTH=8.
// Expected {Bout,diff} queued at start, checked at done.
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       start4 = 1'b0;
  logic [3:0] a4 = '0;
  logic [3:0] b4 = '0;
  logic       bin4 = 1'b0;
  logic [3:0] diff4;
  logic       bout4;
  logic       busy4;
  logic       done4;

  logic       start8 = 1'b0;
  logic [7:0] a8 = '0;
  logic [7:0] b8 = '0;
  logic       bin8 = 1'b0;
  logic [7:0] diff8;
  logic       bout8;
  logic       busy8;
  logic       done8;

  int         n_chk = 0;
  int         n_fail = 0;
  logic [4:0] q4[$];
  logic [8:0] q8[$];
  logic [4:0] last4 = '0;
  logic [8:0] last8 = '0;
  logic [4:0] e4;
  logic [8:0] e8;

  serial_subtractor #(.WIDTH(4)) u_dut4 (
    .clk  (clk),
    .rst  (rst),
    .start(start4),
    .A    (a4),
    .B    (b4),
    .Bin  (bin4),
    .diff (diff4),
    .Bout (bout4),
    .busy (busy4),
    .done (done4)
  );

  serial_subtractor #(.WIDTH(8)) u_dut8 (
    .clk  (clk),
    .rst  (rst),
    .start(start8),
    .A    (a8),
    .B    (b8),
    .Bin  (bin8),
    .diff (diff8),
    .Bout (bout8),
    .busy (busy8),
    .done (done8)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (done4 === 1'b1) begin
      chk("q4_pending_at_done", 64'(q4.size() != 0), 64'(1));
      if (q4.size() != 0) begin
        e4 = q4.pop_front();
        chk("res4", {bout4, diff4}, e4);
      end
      last4 = {bout4, diff4};
    end else if (busy4 === 1'b1) begin
      chk("hold4", {bout4, diff4}, last4);
    end
    if (done8 === 1'b1) begin
      chk("q8_pending_at_done", 64'(q8.size() != 0), 64'(1));
      if (q8.size() != 0) begin
        e8 = q8.pop_front();
        chk("res8", {bout8, diff8}, e8);
      end
      last8 = {bout8, diff8};
    end else if (busy8 === 1'b1) begin
      chk("hold8", {bout8, diff8}, last8);
    end
  end

  // mode 0: plain, 1: stray start mid-RUN, 2: operands churn
  task automatic run4(input logic [3:0] a, input logic [3:0] b,
                      input logic bin, input logic [4:0] e,
                      input int mode);
    int cyc;
    @(negedge clk);
    a4 = a;
    b4 = b;
    bin4 = bin;
    start4 = 1'b1;
    q4.push_back(e);
    @(posedge clk);
    #1;
    chk("busy_acc4", busy4, 1);
    cyc = 0;
    while (done4 !== 1'b1 && cyc < 20) begin
      start4 = (mode == 1 && cyc == 2);
      if (start4 || mode == 2) begin
        a4 = 4'($urandom);
        b4 = 4'($urandom);
        bin4 = 1'($urandom);
      end
      @(posedge clk);
      #1;
      cyc++;
      chk("busy_run4", busy4, 1);
    end
    start4 = 1'b0;
    chk("lat4", cyc, 4);
    @(posedge clk);
    #1;
    chk("done_end4", done4, 0);
    chk("busy_end4", busy4, 0);
  endtask

  task automatic run8(input logic [7:0] a, input logic [7:0] b,
                      input logic bin, input logic [8:0] e);
    int cyc;
    @(negedge clk);
    a8 = a;
    b8 = b;
    bin8 = bin;
    start8 = 1'b1;
    q8.push_back(e);
    @(posedge clk);
    #1;
    start8 = 1'b0;
    cyc = 0;
    while (done8 !== 1'b1 && cyc < 30) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("lat8", cyc, 8);
    @(posedge clk);
    #1;
    chk("busy_end8", busy8, 0);
  endtask

  initial begin
    int t[3];
    int nd;
    int cyc;
    logic [3:0] ra, rb;
    logic       rc;
    logic [4:0] s5;
    logic [7:0] sa, sb;
    logic [8:0] s9;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_diff4", diff4, 0);
    chk("rst_bout4", bout4, 0);
    chk("rst_busy4", busy4, 0);
    chk("rst_done4", done4, 0);
    chk("rst_busy8", busy8, 0);
    rst = 1'b0;

    run4(4'b0101, 4'b1010, 1'b0, 5'b11011, 0);
    run4(4'b1101, 4'b1011, 1'b1, 5'b00001, 0);
    run4(4'b0101, 4'b1110, 1'b0, 5'b10111, 0);
    run4(4'b1111, 4'b1010, 1'b1, 5'b00100, 0);

    run4(4'b0000, 4'b0000, 1'b1, 5'b11111, 0);
    run4(4'b1111, 4'b1111, 1'b0, 5'b00000, 0);
    run4(4'b0000, 4'b1111, 1'b1, 5'b10000, 0);

    run4(4'b0110, 4'b0010, 1'b1, 5'b00011, 1);
    run4(4'b0011, 4'b0111, 1'b0, 5'b11100, 2);

    @(negedge clk);
    a4 = 4'b1001;
    b4 = 4'b0011;
    bin4 = 1'b0;
    start4 = 1'b1;
    repeat (3) q4.push_back(5'b00110);
    nd = 0;
    cyc = 0;
    t = '{0, 0, 0};
    while (nd < 3 && cyc < 60) begin
      @(posedge clk);
      #1;
      cyc++;
      if (done4 === 1'b1) begin
        t[nd] = cyc;
        nd++;
      end
    end
    start4 = 1'b0;
    chk("b2b_count", nd, 3);
    chk("b2b_gap1", t[1] - t[0], 6);
    chk("b2b_gap2", t[2] - t[1], 6);
    @(posedge clk);
    #1;
    chk("b2b_busy_end", busy4, 0);

    @(negedge clk);
    a4 = 4'b0011;
    b4 = 4'b0001;
    bin4 = 1'b0;
    start4 = 1'b1;
    @(posedge clk);
    #1;
    start4 = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    last4 = '0;
    last8 = '0;
    chk("mrst_diff4", diff4, 0);
    chk("mrst_bout4", bout4, 0);
    chk("mrst_busy4", busy4, 0);
    chk("mrst_done4", done4, 0);
    repeat (6) @(posedge clk);
    run4(4'b0101, 4'b1010, 1'b0, 5'b11011, 0);

    for (int i = 0; i < 1000; i++) begin
      ra = 4'($urandom);
      rb = 4'($urandom);
      rc = 1'($urandom);
      if (i % 4 == 3) begin
        s5 = {1'b0, ra} + {1'b0, rb} + {4'b0, rc};
        run4(s5[3:0], rb, rc, {s5[4], ra}, 0);
      end else begin
        s5 = {1'b0, ra} - {1'b0, rb} - {4'b0, rc};
        run4(ra, rb, rc, s5, 0);
      end
    end

    for (int i = 0; i < 1000; i++) begin
      sa = 8'($urandom);
      sb = 8'($urandom);
      rc = 1'($urandom);
      if (i % 4 == 3) begin
        s9 = {1'b0, sa} + {1'b0, sb} + {8'b0, rc};
        run8(s9[7:0], sb, rc, {s9[8], sa});
      end else begin
        s9 = {1'b0, sa} - {1'b0, sb} - {8'b0, rc};
        run8(sa, sb, rc, s9);
      end
    end

    repeat (3) @(posedge clk);
    #1;
    chk("q4_drained", q4.size(), 0);
    chk("q8_drained", q8.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial WIDTH-bit binary subtractor with borrow-in/borrow-out. It is the inverse companion to the combinational 4-bit binary adder: it computes A − B − Bin one bit per clock, LSB first, behind a start/busy/done handshake. It is the small-area arithmetic path for sequential datapaths, and its results cross-check adder results (A + B + Cin, then subtract back).

## Interface
- WIDTH, default 4: operand and result width in bits; legal range 2..32.

- clk  input  1  rising-edge clock; sole clock domain.
- rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
- start  input  1  request; sampled only in IDLE.
- A  input  WIDTH  minuend; sampled on the accepting edge only.
- B  input  WIDTH  subtrahend; sampled on the accepting edge only.
- Bin  input  1  borrow-in; sampled on the accepting edge only.
- diff  output  WIDTH  difference, registered.
- Bout  output  1  borrow-out, registered.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle pulse; results valid.

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - On start=1, latch A, B and Bin into internal shift/borrow registers.
  - Clear the bit counter to 0 and go to RUN.
  - diff and Bout keep their previous values.
- RUN, one bit per edge:
  - a = A_sh[0], b = B_sh[0], br = borrow register.
  - Difference bit d = a ^ b ^ br.
  - Next borrow = (~a & b) | (~(a ^ b) & br).
  - Shift d into the result register from the MSB end. Shift A_sh and B_sh right. Increment the counter.
  - After the WIDTH-th bit, go to DONE.
- DONE:
  - Present the completed result on diff; present the final borrow on Bout.
  - done=1 for exactly this state.
  - Next edge: return to IDLE unconditionally.
- diff and Bout update only on the RUN→DONE transition. They hold until the next completed operation.
- start is ignored in RUN and DONE; there is no queuing. A start held high through DONE is accepted in the following IDLE cycle.
- A, B and Bin may change freely after the accepting edge without affecting the operation.
- Arithmetic: {Bout, diff} = (A − B − Bin) mod 2^(WIDTH+1).
  - Bout=1 iff A < B + Bin (unsigned).
  - Width-exact; no saturation.
- Reset, at any time including mid-RUN:
  - State goes to IDLE; the counter, shift registers and borrow register clear.
  - diff=0, Bout=0, busy=0, done=0.
  - The partial result is discarded. start is not accepted on the reset edge.

## Timing
- Reset values: diff=0, Bout=0, busy=0, done=0, state IDLE.
- Edge k: start=1 is sampled in IDLE. busy=1 from after edge k.
- Edges k+1 … k+WIDTH: one bit processed per edge.
- After edge k+WIDTH: state DONE, done=1, diff/Bout valid.
- After edge k+WIDTH+1: IDLE, done=0, busy=0.
- Latency: start sample to done high is WIDTH cycles.
- Issue interval: minimum WIDTH+2 cycles between accepted starts.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Test plan
- After reset with WIDTH=4, run four operations; each must give exactly one done pulse, 4 cycles after start, with busy high for 5 cycles:

  | A | B | Bin | diff | Bout |
  |---|---|---|---|---|
  | 0101 | 1010 | 0 | 1011 | 1 |
  | 1101 | 1011 | 1 | 0001 | 0 |
  | 0101 | 1110 | 0 | 0111 | 1 |
  | 1111 | 1010 | 1 | 0100 | 0 |

- Boundary operands:
  - A=0000, B=0000, Bin=1 → diff=1111, Bout=1.
  - A=1111, B=1111, Bin=0 → diff=0000, Bout=0.
  - A=0000, B=1111, Bin=1 → diff=0000, Bout=1.
- Start during an operation:
  - Pulse start with new operands 2 cycles into RUN → ignored. The result and done timing match the original operation.
  - Hold start high continuously → back-to-back operations every 6 cycles.
- Operand changes after acceptance:
  - Change A, B and Bin every cycle after the accepting edge → the result equals the latched operands.
  - diff and Bout hold their old values throughout RUN.
- Reset mid-RUN:
  - Assert rst for 1 cycle at the 2nd RUN edge → next cycle diff=0, Bout=0, busy=0, with no done pulse.
  - A subsequent start of 0101 − 1010 gives diff=1011, Bout=1.
- Randomized self-check: 1000 random A, B and Bin at WIDTH=4 and WIDTH=8 against {Bout, diff} = A − B − Bin mod 2^(WIDTH+1).
  - Also the round trip: feed the adder's {Cout, sum} back and check that A − B returns sum − Cin correctly.
